// File: rtl/uctrl_fetch_pkg.sv
// uctrl_fetch_pkg: shared widths, fetch entry type and PC alignment helper for the prefetch unit
package uctrl_fetch_pkg;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int PC_STEP = 4;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: flushable FIFO whose head is held in its own register so outputs come straight from flops
module fetch_fifo
  import uctrl_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t head_q, head_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d, rem;
  logic wr_en;
  always_comb begin
    wr_en = push_i && !flush_i;
    rd_d = rd_q + PW'(pop_i);
    rem = cnt_q - CW'(pop_i);
    wr_d = flush_i ? rd_d : wr_q + PW'(wr_en);
    cnt_d = flush_i ? '0 : rem + CW'(wr_en);
    // when nothing survives the pop, the incoming word becomes the head directly
    head_d = (cnt_d == '0) ? head_q : (rem == '0) ? wdata_i : mem_q[rd_d];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      head_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      head_q <= head_d;
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= wdata_i;
  assign head_o = head_q;
  assign count_o = cnt_q;
endmodule

// File: rtl/rom_prefetch_unit.sv
// rom_prefetch_unit: sequential ROM fetch with redirect flush, MBIST hold and a decode-side FIFO
module rom_prefetch_unit
  import uctrl_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              align_err,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  input  logic              rom_ready,
  input  logic              mbist_en
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, rom_addr_q, rom_addr_d, resp_pc_q, redir_pc;
  logic rom_req_q, rom_req_d, inflight_q, kill_q, align_err_q, pop, push, issue;
  logic [CW-1:0] count;
  logic [CW:0] used;
  fetch_entry_t wentry, head;
  always_comb begin
    pop = instr_valid && instr_ready;
    push = rom_ready && inflight_q && !kill_q;
    redir_pc = word_align(redirect_pc);
    // credit covers the request on the bus and the response arriving now
    used = (CW+1)'(count) + (CW+1)'(inflight_q) + (CW+1)'(rom_req_q) - (CW+1)'(pop);
    issue = !mbist_en && !redirect_valid && used < (CW+1)'(DEPTH);
    // a redirect launches its own request so the new address is on the bus next cycle
    rom_req_d = redirect_valid ? !mbist_en : issue;
    rom_addr_d = redirect_valid ? redir_pc : issue ? fetch_pc_q : rom_addr_q;
    fetch_pc_d = redirect_valid ? redir_pc + (rom_req_d ? ADDR_W'(PC_STEP) : '0)
               : issue ? fetch_pc_q + ADDR_W'(PC_STEP) : fetch_pc_q;
    wentry = '{data: rom_rdata, pc: resp_pc_q};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rom_addr_q <= RESET_PC;
      rom_req_q <= 1'b0;
      inflight_q <= 1'b0;
      kill_q <= 1'b0;
      align_err_q <= 1'b0;
      resp_pc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rom_addr_q <= rom_addr_d;
      rom_req_q <= rom_req_d;
      inflight_q <= rom_req_q;
      kill_q <= redirect_valid;
      align_err_q <= redirect_valid && |redirect_pc[1:0];
      resp_pc_q <= rom_addr_q;
    end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wentry),
    .head_o  (head),
    .count_o (count)
  );
  assign instr_valid = count != '0;
  assign instr_data = head.data;
  assign instr_pc = head.pc;
  assign align_err = align_err_q;
  assign rom_req = rom_req_q;
  assign rom_addr = rom_addr_q;
endmodule

// File: tb/tb_rom_prefetch_unit.sv
// tb_rom_prefetch_unit: directed and random fetch scenarios checked against an in-order PC/data scoreboard
module tb_rom_prefetch_unit;
  logic clk, rst_n, redirect_valid, instr_valid, instr_ready, align_err;
  logic rom_req, rom_ready, mbist_en, noise;
  logic [14:0] redirect_pc, instr_pc, rom_addr, exp_pc;
  logic [31:0] instr_data, rom_rdata;
  logic exp_align;
  int total = 0, bad = 0, n_acc = 0, n_req = 0;

  rom_prefetch_unit #(.DEPTH(4), .RESET_PC(15'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .align_err(align_err), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_rdata(rom_rdata), .rom_ready(rom_ready), .mbist_en(mbist_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] romw(input logic [14:0] a);
    return 32'hDEAD_0000 + 32'(a[14:2]);
  endfunction

  // ROM answers one cycle after a sampled request; during MBIST it also emits unrelated traffic
  initial begin
    rom_ready = 1'b0;
    rom_rdata = '0;
  end
  always @(posedge clk) begin
    rom_ready <= rom_req || (noise && $urandom_range(0, 1) == 1);
    rom_rdata <= rom_req ? romw(rom_addr) : $urandom;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    chk("align_err", 64'(align_err), 64'(exp_align));
    if (instr_valid && instr_ready) begin
      chk("pop_pc", 64'(instr_pc), 64'(exp_pc));
      chk("pop_data", 64'(instr_data), 64'(romw(exp_pc)));
      exp_pc = exp_pc + 15'd4;
      n_acc++;
    end
    if (redirect_valid) begin
      exp_pc = {redirect_pc[14:2], 2'b00};
      exp_align = |redirect_pc[1:0];
    end else exp_align = 1'b0;
    @(negedge clk);
  endtask

  task automatic redirect(input logic [14:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    cyc();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    mbist_en = 1'b0; noise = 1'b0; exp_pc = '0; exp_align = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(rom_req), 0);
    chk("rst_addr", 64'(rom_addr), 0);
    chk("rst_valid", 64'(instr_valid), 0);
    chk("rst_data", 64'(instr_data), 0);
    chk("rst_pc", 64'(instr_pc), 0);
    chk("rst_align", 64'(align_err), 0);
    rst_n = 1'b1;
    cyc();
    chk("first_req", 64'(rom_req), 1);
    chk("first_addr", 64'(rom_addr), 0);
    instr_ready = 1'b1;
    repeat (5) cyc();
    n_acc = 0;
    repeat (20) cyc();
    chk("throughput", 64'(n_acc), 20);

    redirect(15'h0100);
    chk("rd_req", 64'(rom_req), 1);
    chk("rd_addr", 64'(rom_addr), 15'h0100);
    chk("rd_v1", 64'(instr_valid), 0);
    cyc();
    chk("rd_v2", 64'(instr_valid), 0);
    cyc();
    chk("rd_v3", 64'(instr_valid), 1);
    chk("rd_pc", 64'(instr_pc), 15'h0100);
    chk("rd_data", 64'(instr_data), 32'hDEAD0040);
    repeat (4) cyc();

    redirect(15'h0022);
    chk("mis_pulse", 64'(align_err), 1);
    chk("mis_addr", 64'(rom_addr), 15'h0020);
    cyc();
    cyc();
    chk("mis_pc", 64'(instr_pc), 15'h0020);
    chk("mis_data", 64'(instr_data), 32'hDEAD0008);
    repeat (3) cyc();

    redirect(15'h7FFC);
    chk("wrap_a0", 64'(rom_addr), 15'h7FFC);
    cyc();
    chk("wrap_a1", 64'(rom_addr), 15'h0000);
    cyc();
    chk("wrap_a2", 64'(rom_addr), 15'h0004);
    repeat (4) cyc();

    instr_ready = 1'b0;
    redirect(15'h0200);
    n_req = 0;
    repeat (20) begin
      n_req += int'(rom_req);
      cyc();
    end
    chk("bp_reqs", 64'(n_req), 4);
    chk("bp_idle", 64'(rom_req), 0);
    chk("bp_valid", 64'(instr_valid), 1);
    instr_ready = 1'b1;
    n_acc = 0;
    repeat (10) cyc();
    chk("bp_drain", 64'(n_acc), 10);

    instr_ready = 1'b0;
    redirect(15'h0300);
    mbist_en = 1'b1;
    noise = 1'b1;
    n_req = 0;
    repeat (100) begin
      cyc();
      n_req += int'(rom_req);
    end
    chk("mb_reqs", 64'(n_req), 0);
    chk("mb_valid", 64'(instr_valid), 1);
    chk("mb_pc", 64'(instr_pc), 15'h0300);
    chk("mb_data", 64'(instr_data), 32'hDEAD00C0);
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    chk("mb_one", 64'(instr_valid), 0);
    mbist_en = 1'b0;
    noise = 1'b0;
    cyc();
    chk("mb_resume_req", 64'(rom_req), 1);
    chk("mb_resume_addr", 64'(rom_addr), 15'h0304);
    instr_ready = 1'b1;
    repeat (10) cyc();

    repeat (400) begin
      instr_ready = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 39) == 0;
      redirect_pc = 15'($urandom);
      cyc();
    end
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    repeat (5) cyc();
    n_acc = 0;
    repeat (10) cyc();
    chk("rand_tail", 64'(n_acc), 10);

    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(instr_valid), 0);
    chk("arst_req", 64'(rom_req), 0);
    chk("arst_pc", 64'(instr_pc), 0);
    #1;
    rst_n = 1'b1;
    exp_pc = '0;
    exp_align = 1'b0;
    cyc();
    chk("arst_req1", 64'(rom_req), 1);
    chk("arst_addr1", 64'(rom_addr), 0);
    n_acc = 0;
    repeat (12) cyc();
    chk("arst_resume", 64'(n_acc), 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
